// File: rtl/stopwatch_seg_source_if.sv
// Bundle between the stopwatch source and its neighbours: two control pulses
// come in, and the count, status and four segment patterns go out.
interface stopwatch_seg_source_if;
    logic        start_stop;
    logic        clear;
    logic [6:0]  seg0;
    logic [6:0]  seg1;
    logic [6:0]  seg2;
    logic [6:0]  seg3;
    logic [15:0] bcd;
    logic        running;
    logic        overflow;

    // The controller side issues the pulses and observes everything else.
    modport master (
        output start_stop, clear,
        input  seg0, seg1, seg2, seg3, bcd, running, overflow
    );

    // The stopwatch side consumes the pulses and drives the display data.
    modport slave (
        input  start_stop, clear,
        output seg0, seg1, seg2, seg3, bcd, running, overflow
    );
endinterface

// File: rtl/stopwatch_seg_source.sv
// Centisecond stopwatch (SS.hh, 00.00..99.99) with registered BCD count and
// registered active-low 7-segment patterns for a downstream digit mux.
module stopwatch_seg_source #(
    parameter int TICK_DIV   = 1000000,
    parameter int BLANK_LEAD = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    stopwatch_seg_source_if.slave     bus
);

    localparam int             PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  TERM = PW'(TICK_DIV - 1);
    localparam logic [6:0]     SEG_ZERO  = 7'b1000000;
    localparam logic [6:0]     SEG_BLANK = 7'b1111111;
    localparam logic [6:0]     SEG3_RST  = (BLANK_LEAD != 0) ? SEG_BLANK : SEG_ZERO;

    typedef enum logic {STOPPED, RUN} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [15:0]    bcd_q, bcd_d;
    logic           running_q;
    logic           overflow_q, overflow_d;
    logic [6:0]     seg0_q, seg1_q, seg2_q, seg3_q;
    logic           tick;

    // BCD digit to active-low {g,f,e,d,c,b,a}; non-decimal codes go dark.
    function automatic logic [6:0] decode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    assign tick = (state_q == RUN) && (presc_q == TERM);

    // Next-state: prescaler advance, ripple BCD increment, then clear and toggle overrides.
    always_comb begin
        logic carry;
        presc_d    = presc_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        state_d    = state_q;
        carry      = tick;
        if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_q[i*4 +: 4] == 4'd9) begin
                    bcd_d[i*4 +: 4] = 4'd0;
                end else begin
                    bcd_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (carry) begin
            overflow_d = 1'b1;
        end
        if (bus.clear) begin
            presc_d    = '0;
            bcd_d      = '0;
            overflow_d = 1'b0;
        end
        if (bus.start_stop) begin
            state_d = (state_q == RUN) ? STOPPED : RUN;
        end
    end

    // State, count and registered outputs; segments trail the count by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= STOPPED;
            presc_q    <= '0;
            bcd_q      <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
            seg0_q     <= SEG_ZERO;
            seg1_q     <= SEG_ZERO;
            seg2_q     <= SEG_ZERO;
            seg3_q     <= SEG3_RST;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            bcd_q      <= bcd_d;
            running_q  <= (state_d == RUN);
            overflow_q <= overflow_d;
            seg0_q     <= decode(bcd_q[3:0]);
            seg1_q     <= decode(bcd_q[7:4]);
            seg2_q     <= decode(bcd_q[11:8]);
            seg3_q     <= ((BLANK_LEAD != 0) && (bcd_q[15:12] == 4'd0)) ? SEG_BLANK
                                                                         : decode(bcd_q[15:12]);
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.running  = running_q;
    assign bus.overflow = overflow_q;
    assign bus.seg0     = seg0_q;
    assign bus.seg1     = seg1_q;
    assign bus.seg2     = seg2_q;
    assign bus.seg3     = seg3_q;

endmodule

// File: tb/tb_stopwatch_seg_source.sv
// Bench for the stopwatch segment source: directed scenarios plus random
// start/stop/clear pulses, compared each clock against a centisecond model.
module tb_stopwatch_seg_source;

    localparam int DIV = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Reference model state, in plain integers.
    int   mCount;
    int   mShown;
    int   mPresc;
    bit   mRun;
    bit   mOvf;

    logic [6:0] segTable [10];

    stopwatch_seg_source_if swIf ();

    stopwatch_seg_source #(.TICK_DIV(DIV), .BLANK_LEAD(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (swIf.slave)
    );

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [15:0] toBcd(input int c);
        logic [15:0] r;
        r[15:12] = 4'((c / 1000) % 10);
        r[11:8]  = 4'((c / 100) % 10);
        r[7:4]   = 4'((c / 10) % 10);
        r[3:0]   = 4'(c % 10);
        return r;
    endfunction

    function automatic logic [6:0] expSeg(input int idx);
        int p;
        int d;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        d = (mShown / p) % 10;
        if (idx == 3 && d == 0) return 7'b1111111;
        return segTable[d];
    endfunction

    task automatic modelReset();
        mCount = 0;
        mShown = 0;
        mPresc = 0;
        mRun   = 0;
        mOvf   = 0;
    endtask

    // One clock edge of the stopwatch, described by its timing rules.
    task automatic modelEdge(input bit ss, input bit cl);
        bit tk;
        mShown = mCount;
        tk = mRun && (mPresc == DIV - 1);
        if (mRun) mPresc = tk ? 0 : mPresc + 1;
        if (tk) begin
            mCount = mCount + 1;
            if (mCount == 10000) begin
                mCount = 0;
                mOvf   = 1;
            end
        end
        if (cl) begin
            mCount = 0;
            mPresc = 0;
            mOvf   = 0;
        end
        if (ss) mRun = !mRun;
    endtask

    task automatic checkAll();
        checkOutput("bcd",      swIf.bcd, toBcd(mCount));
        checkOutput("running",  {15'd0, swIf.running}, {15'd0, mRun});
        checkOutput("overflow", {15'd0, swIf.overflow}, {15'd0, mOvf});
        checkOutput("seg0",     {9'd0, swIf.seg0}, {9'd0, expSeg(0)});
        checkOutput("seg1",     {9'd0, swIf.seg1}, {9'd0, expSeg(1)});
        checkOutput("seg2",     {9'd0, swIf.seg2}, {9'd0, expSeg(2)});
        checkOutput("seg3",     {9'd0, swIf.seg3}, {9'd0, expSeg(3)});
    endtask

    // Present pulses for one edge, advance the model and check just after the edge.
    task automatic applyStimulus(input bit ss, input bit cl);
        swIf.start_stop = ss;
        swIf.clear      = cl;
        @(posedge clk);
        modelEdge(ss, cl);
        #1;
        swIf.start_stop = 0;
        swIf.clear      = 0;
        checkAll();
    endtask

    task automatic runUntil(input string tag, input int target, input int limit);
        int n;
        n = 0;
        while (mCount != target && n < limit) begin
            applyStimulus(0, 0);
            n++;
        end
        checkOutput(tag, swIf.bcd, toBcd(target));
    endtask

    initial begin
        segTable = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                     7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        checks = 0;
        errors = 0;
        clk = 0;
        reset = 1;
        swIf.start_stop = 0;
        swIf.clear = 0;
        modelReset();

        // Reset state, then idle with no pulses.
        #12;
        checkAll();
        reset = 0;
        for (int i = 0; i < 10; i++) applyStimulus(0, 0);
        checkOutput("t1_seg3_blank", {9'd0, swIf.seg3}, 16'h007F);

        // Start and run 40 clocks: ten ticks.
        applyStimulus(1, 0);
        for (int i = 0; i < 40; i++) applyStimulus(0, 0);
        checkOutput("t2_bcd", swIf.bcd, 16'h0010);
        applyStimulus(0, 0);
        checkOutput("t2_seg1", {9'd0, swIf.seg1}, 16'h0079);

        // Pause at 01.23, hold, resume.
        runUntil("t4_reach", 123, 2000);
        applyStimulus(1, 0);
        for (int i = 0; i < 50; i++) applyStimulus(0, 0);
        checkOutput("t4_hold", swIf.bcd, 16'h0123);
        applyStimulus(1, 0);
        runUntil("t4_resume", 124, 20);

        // Clear while running, count to 00.57, then clear + stop together.
        applyStimulus(0, 1);
        runUntil("t5_reach", 57, 1000);
        applyStimulus(1, 1);
        checkOutput("t5_bcd", swIf.bcd, 16'h0000);
        checkOutput("t5_run", {15'd0, swIf.running}, 16'h0000);

        // Full wrap 99.99 -> 00.00, then clear the sticky overflow.
        applyStimulus(1, 0);
        runUntil("t3_9999", 9999, 45000);
        runUntil("t3_wrap", 0, 10);
        checkOutput("t3_ovf", {15'd0, swIf.overflow}, 16'h0001);
        applyStimulus(0, 0);
        checkOutput("t3_seg3", {9'd0, swIf.seg3}, 16'h007F);
        applyStimulus(0, 1);
        checkOutput("t3_clr_ovf", {15'd0, swIf.overflow}, 16'h0000);

        // Random pulse traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
        end

        // Ensure running, then asynchronous reset between edges.
        if (!mRun) applyStimulus(1, 0);
        for (int i = 0; i < 9; i++) applyStimulus(0, 0);
        #2;
        reset = 1;
        #1;
        modelReset();
        checkAll();
        #1;
        reset = 0;
        for (int i = 0; i < 20; i++) applyStimulus(0, 0);
        checkOutput("t6_idle", swIf.bcd, 16'h0000);
        applyStimulus(1, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
